// File: rtl/interleaver_pkg.sv
// Shared constants for the convolutional interleaver/deinterleaver SRAM layout.
package interleaver_pkg;

  localparam int unsigned NBR  = 8;   // branches
  localparam int unsigned NSEG = 24;  // segments per branch, pointer modulus
  localparam int unsigned SEGW = 64;  // words per segment
  localparam int unsigned AW   = 14;  // SRAM address width

  localparam int unsigned BW   = 3;   // branch index width
  localparam int unsigned CW   = 6;   // column width
  localparam int unsigned SW   = 5;   // segment pointer width
  localparam int unsigned MW   = 8;   // segment-row (msb) width
  localparam int unsigned CNTW = BW + CW;

  // Interleaver write offsets: mod-24 complements of the deinterleaver offsets.
  localparam logic [SW-1:0] OFF [NBR] = '{
    5'd0, 5'd12, 5'd18, 5'd6, 5'd3, 5'd21, 5'd9, 5'd15
  };

  // Receive-side deinterleaver offsets sharing the same SRAM layout.
  localparam logic [SW-1:0] DEINT_OFF [NBR] = '{
    5'd0, 5'd12, 5'd6, 5'd18, 5'd21, 5'd3, 5'd15, 5'd9
  };

endpackage

// File: rtl/mod24_ctr.sv
// Segment base pointer: counts 0..NSEG-1 and wraps, with synchronous clear.
module mod24_ctr
  import interleaver_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_i,
  input  logic          inc_i,
  output logic [SW-1:0] cnt_o,
  output logic          wrap_o
);

  logic [SW-1:0] cnt_q;

  assign wrap_o = inc_i && (cnt_q == SW'(NSEG - 1));
  assign cnt_o  = cnt_q;

  // Pointer register; clear wins over increment.
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      cnt_q <= '0;
    end else if (inc_i) begin
      cnt_q <= wrap_o ? '0 : cnt_q + SW'(1);
    end
  end

endmodule

// File: rtl/interleaver_addr_gen.sv
// Transmit-side convolutional interleaver SRAM address/strobe generator.
// Each sample costs a write cycle followed by a read cycle.
module interleaver_addr_gen
  import interleaver_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          en_in,
  output logic [AW-1:0] ADDR,
  output logic          NWRT,
  output logic          NCE,
  output logic          en_out
);

  logic            active_q;
  logic            ph_q;
  logic [CNTW-1:0] cnt_q;
  logic            filled_q;
  logic            en_out_q;

  logic [SW-1:0]   base;
  logic            base_inc;
  logic            base_wrap;
  logic            start;
  logic            frame_end;

  assign start     = !active_q && en_in;
  assign frame_end = active_q && ph_q && (cnt_q == {CNTW{1'b1}});
  assign base_inc  = frame_end;

  mod24_ctr u_base (
    .clk    (clk),
    .rst    (rst),
    .clr_i  (start),
    .inc_i  (base_inc),
    .cnt_o  (base),
    .wrap_o (base_wrap)
  );

  // Sequencing state: start, write/read phase toggle, sample counter, fill flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      active_q <= 1'b0;
      ph_q     <= 1'b0;
      cnt_q    <= '0;
      filled_q <= 1'b0;
      en_out_q <= 1'b0;
    end else begin
      en_out_q <= active_q && ph_q && filled_q;
      if (!active_q) begin
        if (en_in) begin
          active_q <= 1'b1;
          ph_q     <= 1'b0;
          cnt_q    <= '0;
        end
      end else begin
        ph_q <= ~ph_q;
        if (ph_q) begin
          cnt_q <= cnt_q + CNTW'(1);
        end
        if (base_wrap) begin
          filled_q <= 1'b1;
        end
      end
    end
  end

  logic [BW-1:0] br;
  logic [CW-1:0] col;
  logic [SW:0]   sum;
  logic [SW-1:0] seg;
  logic [MW-1:0] msb;

  // Address decode: write uses the offset pointer, read uses the base pointer.
  always_comb begin
    br  = cnt_q[BW-1:0];
    col = cnt_q[CNTW-1:BW];
    sum = {1'b0, base} + {1'b0, OFF[br]};
    // Both operands are below 24, so one conditional subtract is a full mod.
    if (sum >= (SW+1)'(NSEG)) begin
      seg = SW'(sum - (SW+1)'(NSEG));
    end else begin
      seg = sum[SW-1:0];
    end
    if (ph_q) begin
      seg = base;
    end
    msb = {3'b000, seg} + ({5'b00000, br} * MW'(NSEG));
    if (active_q) begin
      ADDR = {msb, col};
      NWRT = ph_q;
      NCE  = 1'b0;
    end else begin
      ADDR = '0;
      NWRT = 1'b1;
      NCE  = 1'b1;
    end
  end

  assign en_out = en_out_q;

endmodule

// File: tb/tb_interleaver_addr_gen.sv
// Directed bench for interleaver_addr_gen with a frame-level golden model.
module tb_interleaver_addr_gen;
  import interleaver_pkg::*;

  logic          clk = 1'b0;
  logic          rst;
  logic          en_in;
  logic [AW-1:0] ADDR;
  logic          NWRT;
  logic          NCE;
  logic          en_out;

  int n_vec = 0;
  int n_mis = 0;
  int wr_frame [12288];

  interleaver_addr_gen dut (
    .clk    (clk),
    .rst    (rst),
    .en_in  (en_in),
    .ADDR   (ADDR),
    .NWRT   (NWRT),
    .NCE    (NCE),
    .en_out (en_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Expected address for the k-th active cycle, built from the deinterleaver table.
  function automatic int model_addr(input int k);
    int ph, c, base, b, col, seg;
    ph   = k % 2;
    c    = (k / 2) % 512;
    base = (k / 1024) % 24;
    b    = c % 8;
    col  = c / 8;
    if (ph == 1) seg = base;
    else         seg = (base + (24 - int'(DEINT_OFF[b])) % 24) % 24;
    return (seg + 24 * b) * 64 + col;
  endfunction

  function automatic int model_en_out(input int k);
    if (k < 1) return 0;
    return (((k - 1) % 2 == 1) && ((k - 1) >= 24576)) ? 1 : 0;
  endfunction

  task automatic chk_idle(input string tag);
    chk({tag, "_nce"},  int'(NCE),    1);
    chk({tag, "_nwrt"}, int'(NWRT),   1);
    chk({tag, "_addr"}, int'(ADDR),   0);
    chk({tag, "_eno"},  int'(en_out), 0);
  endtask

  // Run ncyc active cycles against the model, starting at active cycle 0.
  task automatic run_model(input int ncyc, input bit chk_delay);
    int a, b, fr;
    for (int i = 0; i < 12288; i++) wr_frame[i] = -1;
    for (int k = 0; k < ncyc; k++) begin
      a  = model_addr(k);
      fr = k / 1024;
      b  = ((k / 2) % 512) % 8;
      chk("run_addr", int'(ADDR), a);
      chk("run_nwrt", int'(NWRT), k % 2);
      chk("run_nce", int'(NCE), 0);
      chk("run_eno", int'(en_out), model_en_out(k));
      if (int'(ADDR) > 12287) chk("addr_range", int'(ADDR), 12287);
      if (k == 1024) chk("f1_c0_w", int'(ADDR), 64);
      if (k == 1025) chk("f1_c0_r", int'(ADDR), 64);
      if (k == 1026) chk("f1_c1_w", int'(ADDR), 2368);
      if (k == 1027) chk("f1_c1_r", int'(ADDR), 1600);
      if (k == 3072 + 10) chk("wrap_b5_w", int'(ADDR), 7680);
      if (k == 3072 + 11) chk("wrap_b5_r", int'(ADDR), 7872);
      if (chk_delay) begin
        if (k % 2 == 0) begin
          wr_frame[int'(ADDR)] = fr;
        end else if (wr_frame[int'(ADDR)] >= 0) begin
          chk("wr_rd_delay", fr - wr_frame[int'(ADDR)],
              (24 - int'(DEINT_OFF[b])) % 24);
        end
      end
      step();
    end
  endtask

  int exp_nwrt [6] = '{0, 1, 0, 1, 0, 1};
  int exp_addr [6] = '{0, 0, 2304, 1536, 4224, 3072};

  initial begin
    rst   = 1'b1;
    en_in = 1'b0;
    repeat (3) step();
    chk_idle("reset");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_idle("idle");
    end

    // Start frame 0: first SRAM cycle follows the en_in edge.
    en_in = 1'b1;
    step();
    en_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("f0_nce", int'(NCE), 0);
      chk("f0_nwrt", int'(NWRT), exp_nwrt[i]);
      chk("f0_addr", int'(ADDR), exp_addr[i]);
      step();
    end

    // Restart cleanly and sweep past the fill point with the golden model.
    rst = 1'b1;
    step();
    rst = 1'b0;
    en_in = 1'b1;
    step();
    en_in = 1'b0;
    run_model(24700, 1'b1);

    // Mid-run reset at active cycle 5000, then replay frame 0.
    rst = 1'b1;
    step();
    rst = 1'b0;
    en_in = 1'b1;
    step();
    en_in = 1'b0;
    run_model(5000, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_idle("midrst");
    step();
    chk_idle("midrst_hold");
    en_in = 1'b1;
    step();
    en_in = 1'b0;
    for (int i = 0; i < 6; i++) begin
      chk("replay_nce", int'(NCE), 0);
      chk("replay_nwrt", int'(NWRT), exp_nwrt[i]);
      chk("replay_addr", int'(ADDR), exp_addr[i]);
      chk("replay_eno", int'(en_out), 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
